pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Parametrised hazard/forwarding controller for the in-order 5-stage core pipeline.
//  Tracks in-flight register writers in a NSTAGE-deep scoreboard that mirrors EX..WB.
//  Emits load-use stalls, per-operand forwarding selects and branch flushes.
//  Sits beside the ID stage; the IF/ID and ID/EX pipeline registers obey its stall/bubble/flush outputs.
// PARAMETERS
//  REG_AW    5  register-address width (2**REG_AW architectural regs; reg 0 hard-wired zero)
//  NSTAGE    3  tracked stages after ID (index 0=EX, 1=MEM, 2=WB); legal range 2..6
//  LOAD_LAT  1  stage index at which load data first becomes forwardable; 1..NSTAGE-1
//  BR_STAGE  1  stage index where br_taken is resolved; 0..NSTAGE-1
// PORTS
//  clock         in   1                 pipeline clock, rising edge
//  reset_n       in   1                 asynchronous, active-low reset
//  id_valid      in   1                 ID holds a real instruction
//  id_rs         in   REG_AW            source A address
//  id_rt         in   REG_AW            source B address
//  id_use_rs     in   1                 instruction reads rs
//  id_use_rt     in   1                 instruction reads rt
//  id_reg_write  in   1                 instruction writes id_dst
//  id_mem_read   in   1                 instruction is a load
//  id_dst        in   REG_AW            destination address (post RegDst mux)
//  br_taken      in   1                 branch/jump taken, resolved at BR_STAGE
//  stall         out  1                 hold PC and IF/ID
//  bubble_ex     out  1                 load NOP into ID/EX
//  flush_vec     out  BR_STAGE+2        bit0=IF/ID, bit1=ID/EX, bit k=stage k-1 register; 1=kill
//  fwd_a_sel     out  3                 0=regfile, k+1=forward from stage k
//  fwd_b_sel     out  3                 same, for rt
// BEHAVIOUR
//  Reset (async, reset_n=0): all scoreboard entries invalid; every output 0 while reset is held and after release.
//  Scoreboard entry = {vld, wr, ld, dst}; entries with dst==0 are stored with wr=0.
//  Each rising edge: entry[k] <= entry[k-1] for k>=1; entry[0] <= ID instr if !stall && !br_taken, else invalid.
//  Outputs combinational from scoreboard + ID inputs (0-cycle latency); no output depends on br_taken through a loop.
//  Match(k,src) = vld&wr&(dst==src)&(src!=0)&use_src&id_valid.
//  stall = bubble_ex = OR over k<LOAD_LAT of Match(k,src) where entry[k].ld, for src in {rs,rt}.
//  fwd_x_sel = k+1 for smallest k with Match(k,src) and (!ld || k>=LOAD_LAT); else 0. Youngest writer wins.
//  br_taken: flush_vec = all ones for that cycle; entries 0..BR_STAGE-1 invalidated at next edge;
//   stall and bubble_ex forced 0 (flush wins over stall); entries >= BR_STAGE keep shifting.
//  Stall repeats each cycle until the load reaches LOAD_LAT (LOAD_LAT consecutive stall cycles max).
//  Simultaneous rs==rt hazard: one stall, both selects identical.
//  Reset mid-stall or mid-flush: scoreboard cleared immediately; no residual stall after release.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: adds outputs perf_stall_cnt[31:0], perf_flush_cnt[31:0];
//   registered, +1 per cycle with stall / br_taken, saturate at 32'hFFFF_FFFF, cleared by reset.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  pipe_pkg: sb_entry_t struct, FWD_REGFILE=0 constant, stage-index localparams, fwd_sel width function.
//  Sub-module pipe_fwd_match: priority matcher over NSTAGE entries for one source; instantiated for rs and rt.
//  Top holds scoreboard shift register, stall/flush logic, optional perf counters.
// TESTING
//  lw $2 then add $3,$2,$4 (LOAD_LAT=1) -> stall=bubble_ex=1 one cycle, then fwd_a_sel=2 (MEM).
//  add $5,$1,$1; sub $6,$5,$5 -> no stall, fwd_a_sel=fwd_b_sel=1 (EX).
//  add $5; add $5; or $7,$5,$0 -> fwd_a_sel=1 (youngest), not 2.
//  writer dst=$0 then reader of $0 -> fwd_a_sel=0, no stall.
//  br_taken=1 while load-use hazard pending -> flush_vec=all ones, stall=0, entry[0] invalid next cycle.
//  reset_n low mid-stall, LOAD_LAT=2 -> outputs 0 asynchronously; with HAZ_PERF_CNT_EN counters read 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Scoreboard entries carry a fixed-width destination field; REG_AW must not exceed SB_DST_W.
package pipe_pkg;

  localparam int SB_DST_W    = 8;
  localparam int FWD_SEL_W   = 3;
  localparam int FWD_REGFILE = 0;

  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  typedef struct packed {
    logic                vld;
    logic                wr;
    logic                ld;
    logic [SB_DST_W-1:0] dst;
  } sb_entry_t;

  // Select encodes regfile (0) plus one code per tracked stage.
  function automatic int fwdSelWidth(input int nstage);
    return $clog2(nstage + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage side bundle of the hazard controller: instruction decode fields in, stall/flush/forward controls out.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW   = 5,
  parameter int BR_STAGE = 1
);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_reg_write;
  logic              id_mem_read;
  logic [REG_AW-1:0] id_dst;
  logic              br_taken;

  logic                stall;
  logic                bubble_ex;
  logic [BR_STAGE+1:0] flush_vec;
  logic [2:0]          fwd_a_sel;
  logic [2:0]          fwd_b_sel;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_reg_write, id_mem_read, id_dst, br_taken,
    input  stall, bubble_ex, flush_vec, fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_reg_write, id_mem_read, id_dst, br_taken,
    output stall, bubble_ex, flush_vec, fwd_a_sel, fwd_b_sel
  );

endinterface

// File: rtl/pipe_fwd_match.sv
// Priority matcher for one source operand against the in-flight writer scoreboard.
// Reports a load-use hazard and the forwarding select of the youngest usable writer.
module pipe_fwd_match
  import pipe_pkg::*;
#(
  parameter int NSTAGE   = 3,
  parameter int LOAD_LAT = 1,
  parameter int REG_AW   = 5,
  parameter int SEL_W    = 2
) (
  input  sb_entry_t [NSTAGE-1:0] sb,
  input  logic [REG_AW-1:0]      src,
  input  logic                   useSrc,
  input  logic                   idValid,
  output logic                   loadUse,
  output logic [SEL_W-1:0]       fwdSel
);

  logic [SB_DST_W-1:0] srcExt;
  logic [NSTAGE-1:0]   hit;

  assign srcExt = SB_DST_W'(src);

  always_comb begin
    hit = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      hit[k] = sb[k].vld & sb[k].wr & (sb[k].dst == srcExt) &
               (src != '0) & useSrc & idValid;
    end
  end

  // Walk oldest to youngest so the youngest eligible writer is the last assignment.
  always_comb begin
    loadUse = 1'b0;
    fwdSel  = SEL_W'(FWD_REGFILE);
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (hit[k] && (!sb[k].ld || k >= LOAD_LAT)) begin
        fwdSel = SEL_W'(k + 1);
      end
      if (hit[k] && sb[k].ld && k < LOAD_LAT) begin
        loadUse = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller beside ID: writer scoreboard over EX..WB, load-use stall, forwarding, branch flush.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush cycle counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NSTAGE   = 3,
  parameter int LOAD_LAT = 1,
  parameter int BR_STAGE = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  pipe_hazard_ctrl_if.slave  hz
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);

  localparam int SEL_W = fwdSelWidth(NSTAGE);

  sb_entry_t [NSTAGE-1:0] sb;
  sb_entry_t              idEntry;
  logic                   loadUseA;
  logic                   loadUseB;
  logic                   hazStall;
  logic [SEL_W-1:0]       selA;
  logic [SEL_W-1:0]       selB;

  // Writes to r0 are architecturally void, so they never enter the scoreboard as writers.
  always_comb begin
    idEntry = '0;
    if (hz.id_valid) begin
      idEntry.vld = 1'b1;
      idEntry.wr  = hz.id_reg_write && (hz.id_dst != '0);
      idEntry.ld  = hz.id_mem_read;
      idEntry.dst = SB_DST_W'(hz.id_dst);
    end
  end

  pipe_fwd_match #(
    .NSTAGE   (NSTAGE),
    .LOAD_LAT (LOAD_LAT),
    .REG_AW   (REG_AW),
    .SEL_W    (SEL_W)
  ) u_match_rs (
    .sb      (sb),
    .src     (hz.id_rs),
    .useSrc  (hz.id_use_rs),
    .idValid (hz.id_valid),
    .loadUse (loadUseA),
    .fwdSel  (selA)
  );

  pipe_fwd_match #(
    .NSTAGE   (NSTAGE),
    .LOAD_LAT (LOAD_LAT),
    .REG_AW   (REG_AW),
    .SEL_W    (SEL_W)
  ) u_match_rt (
    .sb      (sb),
    .src     (hz.id_rt),
    .useSrc  (hz.id_use_rt),
    .idValid (hz.id_valid),
    .loadUse (loadUseB),
    .fwdSel  (selB)
  );

  // A taken branch kills the stalled instruction anyway, so the flush overrides the stall.
  assign hazStall     = (loadUseA | loadUseB) & ~hz.br_taken;
  assign hz.stall     = hazStall;
  assign hz.bubble_ex = hazStall;
  assign hz.flush_vec = {(BR_STAGE + 2){hz.br_taken & reset_n}};
  assign hz.fwd_a_sel = FWD_SEL_W'(selA);
  assign hz.fwd_b_sel = FWD_SEL_W'(selB);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sb <= '0;
    end else begin
      sb[STG_EX] <= (hazStall || hz.br_taken) ? '0 : idEntry;
      for (int k = 1; k < NSTAGE; k++) begin
        sb[k] <= (hz.br_taken && k < BR_STAGE) ? '0 : sb[k-1];
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (hazStall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (hz.br_taken && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default build plus a LOAD_LAT=2 instance sharing the same ID stream.
// Counter checks compile in only when HAZ_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

  logic clock;
  logic reset_n;
  int   nTests = 0;
  int   nFail  = 0;

  pipe_hazard_ctrl_if #(.REG_AW(5), .BR_STAGE(1)) if1 ();
  pipe_hazard_ctrl_if #(.REG_AW(5), .BR_STAGE(1)) if2 ();

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stallCnt1, flushCnt1, stallCnt2, flushCnt2;
`endif

  pipe_hazard_ctrl #(.REG_AW(5), .NSTAGE(3), .LOAD_LAT(1), .BR_STAGE(1)) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .hz      (if1)
`ifdef HAZ_PERF_CNT_EN
    ,
    .perf_stall_cnt (stallCnt1),
    .perf_flush_cnt (flushCnt1)
`endif
  );

  pipe_hazard_ctrl #(.REG_AW(5), .NSTAGE(3), .LOAD_LAT(2), .BR_STAGE(1)) dut2 (
    .clock   (clock),
    .reset_n (reset_n),
    .hz      (if2)
`ifdef HAZ_PERF_CNT_EN
    ,
    .perf_stall_cnt (stallCnt2),
    .perf_flush_cnt (flushCnt2)
`endif
  );

  assign if2.id_valid     = if1.id_valid;
  assign if2.id_rs        = if1.id_rs;
  assign if2.id_rt        = if1.id_rt;
  assign if2.id_use_rs    = if1.id_use_rs;
  assign if2.id_use_rt    = if1.id_use_rt;
  assign if2.id_reg_write = if1.id_reg_write;
  assign if2.id_mem_read  = if1.id_mem_read;
  assign if2.id_dst       = if1.id_dst;
  assign if2.br_taken     = if1.br_taken;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setInstr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic uRs, input logic uRt, input logic wr,
                          input logic ld, input logic [4:0] dst);
    if1.id_valid     = v;
    if1.id_rs        = rs;
    if1.id_rt        = rt;
    if1.id_use_rs    = uRs;
    if1.id_use_rt    = uRt;
    if1.id_reg_write = wr;
    if1.id_mem_read  = ld;
    if1.id_dst       = dst;
  endtask

  initial begin
    reset_n = 1'b0;
    setInstr(0, 0, 0, 0, 0, 0, 0, 0);
    if1.br_taken = 1'b1;
    #2;
    chk("rst_stall",   32'(if1.stall),     32'd0);
    chk("rst_bubble",  32'(if1.bubble_ex), 32'd0);
    chk("rst_flush",   32'(if1.flush_vec), 32'd0);
    chk("rst_fwd_a",   32'(if1.fwd_a_sel), 32'd0);
    chk("rst_fwd_b",   32'(if1.fwd_b_sel), 32'd0);
    if1.br_taken = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;

    // lw $2 ; add $3,$2,$4
    setInstr(1, 0, 0, 0, 0, 1, 1, 5'd2);
    #1 chk("lw_issue_stall", 32'(if1.stall), 32'd0);
    @(negedge clock);
    setInstr(1, 5'd2, 5'd4, 1, 1, 1, 0, 5'd3);
    #1;
    chk("lu_stall",  32'(if1.stall),     32'd1);
    chk("lu_bubble", 32'(if1.bubble_ex), 32'd1);
    chk("lu_fwd_a",  32'(if1.fwd_a_sel), 32'd0);
    chk("lu_fwd_b",  32'(if1.fwd_b_sel), 32'd0);
    @(negedge clock);
    #1;
    chk("lu_rel_stall", 32'(if1.stall),     32'd0);
    chk("lu_rel_fwd_a", 32'(if1.fwd_a_sel), 32'd2);
    chk("lu_rel_fwd_b", 32'(if1.fwd_b_sel), 32'd0);

    // add $5,$1,$1 ; sub $6,$5,$5
    @(negedge clock);
    setInstr(1, 5'd1, 5'd1, 1, 1, 1, 0, 5'd5);
    #1 chk("add5_fwd_a", 32'(if1.fwd_a_sel), 32'd0);
    @(negedge clock);
    setInstr(1, 5'd5, 5'd5, 1, 1, 1, 0, 5'd6);
    #1;
    chk("ex_stall", 32'(if1.stall),     32'd0);
    chk("ex_fwd_a", 32'(if1.fwd_a_sel), 32'd1);
    chk("ex_fwd_b", 32'(if1.fwd_b_sel), 32'd1);

    // add $5 ; add $5 ; or $7,$5,$0
    @(negedge clock);
    setInstr(1, 0, 0, 0, 0, 1, 0, 5'd5);
    @(negedge clock);
    setInstr(1, 0, 0, 0, 0, 1, 0, 5'd5);
    @(negedge clock);
    setInstr(1, 5'd5, 5'd0, 1, 1, 1, 0, 5'd7);
    #1;
    chk("young_fwd_a", 32'(if1.fwd_a_sel), 32'd1);
    chk("young_fwd_b", 32'(if1.fwd_b_sel), 32'd0);

    // load to $0, then reader of $0
    @(negedge clock);
    setInstr(1, 0, 0, 0, 0, 1, 1, 5'd0);
    @(negedge clock);
    setInstr(1, 5'd0, 5'd0, 1, 1, 1, 0, 5'd8);
    #1;
    chk("r0_stall", 32'(if1.stall),     32'd0);
    chk("r0_fwd_a", 32'(if1.fwd_a_sel), 32'd0);
    chk("r0_fwd_b", 32'(if1.fwd_b_sel), 32'd0);

    // lw $12 ; add $13,$12,$12
    @(negedge clock);
    setInstr(1, 0, 0, 0, 0, 1, 1, 5'd12);
    @(negedge clock);
    setInstr(1, 5'd12, 5'd12, 1, 1, 1, 0, 5'd13);
    #1;
    chk("same_stall", 32'(if1.stall),     32'd1);
    chk("same_fwd_a", 32'(if1.fwd_a_sel), 32'd0);
    chk("same_fwd_b", 32'(if1.fwd_b_sel), 32'd0);
    @(negedge clock);
    #1;
    chk("same_rel_stall", 32'(if1.stall),     32'd0);
    chk("same_rel_fwd_a", 32'(if1.fwd_a_sel), 32'd2);
    chk("same_rel_fwd_b", 32'(if1.fwd_b_sel), 32'd2);

    // lw $20 ; sources not used ; then bubble in ID
    @(negedge clock);
    setInstr(1, 0, 0, 0, 0, 1, 1, 5'd20);
    @(negedge clock);
    setInstr(1, 5'd20, 5'd20, 0, 0, 1, 0, 5'd21);
    #1 chk("nouse_stall", 32'(if1.stall), 32'd0);
    @(negedge clock);
    setInstr(0, 5'd20, 5'd20, 1, 1, 1, 0, 5'd21);
    #1 chk("novalid_fwd_a", 32'(if1.fwd_a_sel), 32'd0);

    // lw $9 ; reader of $9 (dst $11) killed by taken branch
    @(negedge clock);
    setInstr(1, 0, 0, 0, 0, 1, 1, 5'd9);
    @(negedge clock);
    setInstr(1, 5'd9, 5'd9, 1, 0, 1, 0, 5'd11);
    if1.br_taken = 1'b1;
    #1;
    chk("br_flush",  32'(if1.flush_vec), 32'h7);
    chk("br_stall",  32'(if1.stall),     32'd0);
    chk("br_bubble", 32'(if1.bubble_ex), 32'd0);
    @(negedge clock);
    if1.br_taken = 1'b0;
    setInstr(1, 5'd11, 5'd9, 1, 1, 1, 0, 5'd14);
    #1;
    chk("post_br_fwd_a", 32'(if1.fwd_a_sel), 32'd0);
    chk("post_br_fwd_b", 32'(if1.fwd_b_sel), 32'd2);
    chk("post_br_stall", 32'(if1.stall),     32'd0);
    chk("post_br_flush", 32'(if1.flush_vec), 32'd0);

    // LOAD_LAT=2 instance: reset asserted in the middle of a two-cycle stall
    @(negedge clock);
    reset_n = 1'b0;
    setInstr(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    setInstr(1, 0, 0, 0, 0, 1, 1, 5'd13);
    @(negedge clock);
    setInstr(1, 5'd13, 5'd0, 1, 0, 1, 0, 5'd14);
    #1;
    chk("ll2_stall_c1",    32'(if2.stall), 32'd1);
    chk("ll1_stall_c1",    32'(if1.stall), 32'd1);
    @(negedge clock);
    #1;
    chk("ll2_stall_c2",    32'(if2.stall),     32'd1);
    chk("ll2_bubble_c2",   32'(if2.bubble_ex), 32'd1);
    chk("ll2_fwd_a_c2",    32'(if2.fwd_a_sel), 32'd0);
    chk("ll1_fwd_a_c2",    32'(if1.fwd_a_sel), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_stall",  32'(if2.stall),     32'd0);
    chk("midrst_bubble", 32'(if2.bubble_ex), 32'd0);
    chk("midrst_fwd_a",  32'(if2.fwd_a_sel), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("midrst_stall_cnt2", stallCnt2, 32'd0);
    chk("midrst_flush_cnt1", flushCnt1, 32'd0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("postrst_stall", 32'(if2.stall),     32'd0);
    chk("postrst_fwd_a", 32'(if2.fwd_a_sel), 32'd0);
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
